// File: rtl/huffman_pkg.sv
// Shared sizes, state encoding and helpers for the Huffman encoder/decoder pair.
package huffman_pkg;

  localparam int NUM_SYM = 6;
  localparam int CODE_W  = 8;
  localparam int SYM_W   = 3;

  typedef enum logic {
    EMPTY  = 1'b0,
    DECODE = 1'b1
  } state_e;

  function automatic logic [3:0] popcount(input logic [CODE_W-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < CODE_W; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/huffman_match.sv
// Compares the candidate accumulator against one (HC, M, L) table entry.
module huffman_match
  import huffman_pkg::*;
(
  input  logic [CODE_W-1:0] nacc_i,
  input  logic [3:0]        nlen_i,
  input  logic [CODE_W-1:0] hc_i,
  input  logic [CODE_W-1:0] m_i,
  input  logic [3:0]        l_i,
  output logic              hit_o
);

  assign hit_o = (m_i != '0) && (nlen_i == l_i) && ((nacc_i & m_i) == (hc_i & m_i));

endmodule

// File: rtl/huffman_decoder.sv
// Serial Huffman bitstream decoder driven by the encoder's HC/M code table.
// Optional per-symbol decode counters when HUFFDEC_CNT_EN is defined.
module huffman_decoder
  import huffman_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             code_valid,
  input  logic [7:0]       HC1,
  input  logic [7:0]       HC2,
  input  logic [7:0]       HC3,
  input  logic [7:0]       HC4,
  input  logic [7:0]       HC5,
  input  logic [7:0]       HC6,
  input  logic [7:0]       M1,
  input  logic [7:0]       M2,
  input  logic [7:0]       M3,
  input  logic [7:0]       M4,
  input  logic [7:0]       M5,
  input  logic [7:0]       M6,
  input  logic             bit_valid,
  input  logic             bit_data,
  output logic             bit_ready,
  output logic             sym_valid,
  output logic [SYM_W-1:0] sym_data,
  output logic             err
`ifdef HUFFDEC_CNT_EN
  ,
  output logic [7:0]       dcnt1,
  output logic [7:0]       dcnt2,
  output logic [7:0]       dcnt3,
  output logic [7:0]       dcnt4,
  output logic [7:0]       dcnt5,
  output logic [7:0]       dcnt6
`endif
);

  state_e            state_q, state_d;
  logic [CODE_W-1:0] hc_q [NUM_SYM];
  logic [CODE_W-1:0] m_q  [NUM_SYM];
  logic [3:0]        l_q  [NUM_SYM];
  logic [CODE_W-1:0] hc_in [NUM_SYM];
  logic [CODE_W-1:0] m_in  [NUM_SYM];
  logic [CODE_W-1:0] acc_q, acc_d, nacc;
  logic [3:0]        len_q, len_d, nlen;
  logic              sym_valid_q, sym_valid_d;
  logic [SYM_W-1:0]  sym_data_q, sym_data_d;
  logic              err_q, err_d;
  logic [NUM_SYM-1:0] hit;
  logic              any_hit;
  logic [SYM_W-1:0]  sym_sel;

  assign hc_in = '{HC1, HC2, HC3, HC4, HC5, HC6};
  assign m_in  = '{M1, M2, M3, M4, M5, M6};

  assign nacc = {acc_q[CODE_W-2:0], bit_data};
  assign nlen = len_q + 4'd1;

  for (genvar g = 0; g < NUM_SYM; g++) begin : g_match
    huffman_match u_match (
      .nacc_i (nacc),
      .nlen_i (nlen),
      .hc_i   (hc_q[g]),
      .m_i    (m_q[g]),
      .l_i    (l_q[g]),
      .hit_o  (hit[g])
    );
  end

  // Descending scan so the lowest-index hit is the last one written.
  always_comb begin
    any_hit = 1'b0;
    sym_sel = '0;
    for (int i = NUM_SYM - 1; i >= 0; i--) begin
      if (hit[i]) begin
        any_hit = 1'b1;
        sym_sel = SYM_W'(i + 1);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    len_d       = len_q;
    sym_valid_d = 1'b0;
    sym_data_d  = sym_data_q;
    err_d       = 1'b0;
    case (state_q)
      EMPTY: begin
        if (code_valid) begin
          state_d = DECODE;
          acc_d   = '0;
          len_d   = '0;
        end
      end
      DECODE: begin
        if (code_valid) begin
          acc_d = '0;
          len_d = '0;
        end else if (bit_valid) begin
          if (any_hit) begin
            sym_valid_d = 1'b1;
            sym_data_d  = sym_sel;
            acc_d       = '0;
            len_d       = '0;
          end else if (nlen == 4'(CODE_W)) begin
            err_d = 1'b1;
            acc_d = '0;
            len_d = '0;
          end else begin
            acc_d = nacc;
            len_d = nlen;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= EMPTY;
      acc_q       <= '0;
      len_q       <= '0;
      sym_valid_q <= 1'b0;
      sym_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      len_q       <= len_d;
      sym_valid_q <= sym_valid_d;
      sym_data_q  <= sym_data_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SYM; i++) begin
        hc_q[i] <= '0;
        m_q[i]  <= '0;
        l_q[i]  <= '0;
      end
    end else if (code_valid) begin
      for (int i = 0; i < NUM_SYM; i++) begin
        hc_q[i] <= hc_in[i];
        m_q[i]  <= m_in[i];
        l_q[i]  <= popcount(m_in[i]);
      end
    end
  end

  assign bit_ready = (state_q == DECODE);
  assign sym_valid = sym_valid_q;
  assign sym_data  = sym_data_q;
  assign err       = err_q;

`ifdef HUFFDEC_CNT_EN
  logic [7:0] cnt_q [NUM_SYM];

  for (genvar g = 0; g < NUM_SYM; g++) begin : g_cnt
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q[g] <= '0;
      end else if (code_valid) begin
        cnt_q[g] <= '0;
      end else if (sym_valid_d && (sym_data_d == SYM_W'(g + 1)) && (cnt_q[g] != 8'hFF)) begin
        cnt_q[g] <= cnt_q[g] + 8'd1;
      end
    end
  end

  assign dcnt1 = cnt_q[0];
  assign dcnt2 = cnt_q[1];
  assign dcnt3 = cnt_q[2];
  assign dcnt4 = cnt_q[3];
  assign dcnt5 = cnt_q[4];
  assign dcnt6 = cnt_q[5];
`endif

endmodule

// File: tb/tb_huffman_decoder.sv
// Directed self-checking bench for huffman_decoder (counter checks when HUFFDEC_CNT_EN is defined).
module tb_huffman_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       code_valid = 1'b0;
  logic [7:0] HC1 = 8'h00, HC2 = 8'h02, HC3 = 8'h06, HC4 = 8'h0E, HC5 = 8'h1E, HC6 = 8'h1F;
  logic [7:0] M1 = 8'h01, M2 = 8'h03, M3 = 8'h07, M4 = 8'h0F, M5 = 8'h1F, M6 = 8'h1F;
  logic       bit_valid = 1'b0;
  logic       bit_data = 1'b0;
  logic       bit_ready;
  logic       sym_valid;
  logic [2:0] sym_data;
  logic       err;
`ifdef HUFFDEC_CNT_EN
  logic [7:0] dcnt1, dcnt2, dcnt3, dcnt4, dcnt5, dcnt6;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  huffman_decoder dut (
    .clk(clk), .reset(reset), .code_valid(code_valid),
    .HC1(HC1), .HC2(HC2), .HC3(HC3), .HC4(HC4), .HC5(HC5), .HC6(HC6),
    .M1(M1), .M2(M2), .M3(M3), .M4(M4), .M5(M5), .M6(M6),
    .bit_valid(bit_valid), .bit_data(bit_data), .bit_ready(bit_ready),
    .sym_valid(sym_valid), .sym_data(sym_data), .err(err)
`ifdef HUFFDEC_CNT_EN
    , .dcnt1(dcnt1), .dcnt2(dcnt2), .dcnt3(dcnt3), .dcnt4(dcnt4), .dcnt5(dcnt5), .dcnt6(dcnt6)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_table();
    code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_data  = b;
    tick();
    bit_valid = 1'b0;
  endtask

  // Stream 10 | 11111 | 110 decodes as 2, 6, 3; 0 marks "no pulse after this bit".
  logic [9:0] stream_bits [10];
  int         stream_sym  [10];
  logic [2:0] last_sym;

  initial begin
    stream_bits = '{1, 0, 1, 1, 1, 1, 1, 1, 1, 0};
    stream_sym  = '{0, 2, 0, 0, 0, 0, 6, 0, 0, 3};

    repeat (3) tick();
    chk("rst_bit_ready", 32'(bit_ready), 0);
    chk("rst_sym_valid", 32'(sym_valid), 0);
    chk("rst_sym_data",  32'(sym_data), 0);
    chk("rst_err",       32'(err), 0);
    reset = 1'b1;
    tick();

    // Bits offered while EMPTY are ignored.
    send_bit(1'b0);
    chk("empty_ready", 32'(bit_ready), 0);
    chk("empty_sym_valid", 32'(sym_valid), 0);

    load_table();
    chk("load_ready", 32'(bit_ready), 1);

    send_bit(1'b0);
    chk("sym1_valid", 32'(sym_valid), 1);
    chk("sym1_data",  32'(sym_data), 1);
    last_sym = 3'd1;

    bit_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bit_data = stream_bits[i][0];
      tick();
      chk($sformatf("stream_valid[%0d]", i), 32'(sym_valid), 32'(stream_sym[i] != 0));
      if (stream_sym[i] != 0) last_sym = 3'(stream_sym[i]);
      chk($sformatf("stream_data[%0d]", i), 32'(sym_data), 32'(last_sym));
      chk($sformatf("stream_err[%0d]", i), 32'(err), 0);
    end
    bit_valid = 1'b0;
    tick();
    chk("idle_sym_valid", 32'(sym_valid), 0);
    chk("idle_sym_hold",  32'(sym_data), 3);

    // Symbol 6 unused: eight 1s never match and raise one err pulse.
    M6 = 8'h00;
    load_table();
    bit_valid = 1'b1;
    bit_data  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("ones_sym_valid[%0d]", i), 32'(sym_valid), 0);
      chk($sformatf("ones_err[%0d]", i), 32'(err), 32'(i == 8));
      chk($sformatf("ones_ready[%0d]", i), 32'(bit_ready), 1);
    end
    bit_valid = 1'b0;
    tick();
    chk("err_single_pulse", 32'(err), 0);

    // Reload in the same cycle as a bit: 1,1 then a 0 that would otherwise complete symbol 3.
    M6 = 8'h1F;
    send_bit(1'b1);
    send_bit(1'b1);
    code_valid = 1'b1;
    bit_valid  = 1'b1;
    bit_data   = 1'b0;
    tick();
    code_valid = 1'b0;
    bit_valid  = 1'b0;
    chk("drop_sym_valid", 32'(sym_valid), 0);
    chk("drop_err", 32'(err), 0);
    send_bit(1'b0);
    chk("after_drop_valid", 32'(sym_valid), 1);
    chk("after_drop_data",  32'(sym_data), 1);

    // Asynchronous reset mid-codeword clears everything at once.
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_ready", 32'(bit_ready), 0);
    chk("arst_sym_data", 32'(sym_data), 0);
    chk("arst_sym_valid", 32'(sym_valid), 0);
    chk("arst_err", 32'(err), 0);
    tick();
    reset = 1'b1;
    bit_valid = 1'b1;
    bit_data  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post_rst_ready[%0d]", i), 32'(bit_ready), 0);
      chk($sformatf("post_rst_valid[%0d]", i), 32'(sym_valid), 0);
    end
    bit_valid = 1'b0;
    load_table();
    send_bit(1'b0);
    chk("post_rst_sym_valid", 32'(sym_valid), 1);
    chk("post_rst_sym_data",  32'(sym_data), 1);

    // 300 back-to-back "0" codewords.
    load_table();
    begin
      int pulses;
      pulses = 0;
      bit_valid = 1'b1;
      bit_data  = 1'b0;
      for (int i = 1; i <= 300; i++) begin
        tick();
        if (sym_valid && sym_data == 3'd1) pulses++;
`ifdef HUFFDEC_CNT_EN
        if (i == 100) chk("dcnt1_at_100", 32'(dcnt1), 100);
`endif
      end
      bit_valid = 1'b0;
      tick();
      chk("burst_pulses", 32'(pulses), 300);
    end
`ifdef HUFFDEC_CNT_EN
    chk("dcnt1_sat", 32'(dcnt1), 255);
    chk("dcnt2", 32'(dcnt2), 0);
    chk("dcnt3", 32'(dcnt3), 0);
    chk("dcnt4", 32'(dcnt4), 0);
    chk("dcnt5", 32'(dcnt5), 0);
    chk("dcnt6", 32'(dcnt6), 0);
    load_table();
    chk("dcnt1_clr_on_load", 32'(dcnt1), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
